// File: rtl/xgmii32_to_xgmii64_packer_pkg.sv
// Shared XGMII types, control-character constants and the word classifier.
//   xgmii32_t : 32-bit XGMII lane group (data[31:0], ctrl[3:0], ena)
//   xgmii64_t : 64-bit XGMII word       (data[63:0], ctrl[7:0], ena)
package xgmii32_to_xgmii64_packer_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic        ena;
  } xgmii32_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        ena;
  } xgmii64_t;

  typedef enum logic [2:0] {
    W_START,
    W_DATA,
    W_TERM,
    W_IDLE,
    W_OTHER
  } word_class_e;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } chk_state_e;

  function automatic word_class_e classify(input logic [31:0] data, input logic [3:0] ctrl);
    word_class_e cls;
    logic [3:0]  mask;
    logic        term_ok;
    term_ok = 1'b0;
    // Terminate: ctrl lanes form a contiguous top-aligned run; its lowest
    // lane carries FD and every lane above it carries Idle.
    for (int unsigned l = 0; l < 4; l++) begin
      mask = 4'hF << l;
      if (ctrl == mask) begin
        term_ok = (data[8*l +: 8] == XGMII_TERM);
        for (int unsigned b = 0; b < 4; b++) begin
          if (b > l && data[8*b +: 8] != XGMII_IDLE) term_ok = 1'b0;
        end
      end
    end
    if (ctrl == 4'b0001 && data[7:0] == XGMII_START)  cls = W_START;
    else if (ctrl == 4'b0000)                          cls = W_DATA;
    else if (ctrl == 4'b1111 && data == {4{XGMII_IDLE}}) cls = W_IDLE;
    else if (term_ok)                                  cls = W_TERM;
    else                                               cls = W_OTHER;
    return cls;
  endfunction

endpackage

// File: rtl/xgmii32_to_xgmii64_packer_frame_check.sv
// In-line XGMII frame checker for the 32-bit stream.
//   clk, rst      : clock, async active-high reset
//   rx_i          : 32-bit XGMII word; only ena=1 cycles are consumed
//   clr_cnt_i     : synchronous clear of both counters (wins over increment)
//   chk_data_o/chk_ctrl_o : word after error substitution (combinational)
//   frame_cnt_o   : saturating count of frames started
//   err_cnt_o     : saturating count of words replaced by error codes
module xgmii32_frame_check
  import xgmii32_to_xgmii64_packer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  xgmii32_t         rx_i,
  input  logic             clr_cnt_i,
  output logic [31:0]      chk_data_o,
  output logic [3:0]       chk_ctrl_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  chk_state_e       state_q, state_d;
  word_class_e      cls;
  logic             err, frame_inc;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    cls       = classify(rx_i.data, rx_i.ctrl);
    state_d   = state_q;
    err       = 1'b0;
    frame_inc = 1'b0;
    if (rx_i.ena) begin
      case (state_q)
        ST_IDLE: begin
          if (cls == W_START) begin
            state_d   = ST_FRAME;
            frame_inc = 1'b1;
          end else if (cls != W_IDLE) begin
            err = 1'b1;
          end
        end
        ST_FRAME: begin
          case (cls)
            W_DATA:  ;
            W_TERM:  state_d = ST_IDLE;
            W_START: begin
              err       = 1'b1;
              frame_inc = 1'b1;
            end
            default: begin
              err     = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end

    chk_data_o = err ? {4{XGMII_ERROR}} : rx_i.data;
    chk_ctrl_o = err ? 4'b1111 : rx_i.ctrl;

    frame_cnt_d = frame_cnt_q;
    if (clr_cnt_i)                           frame_cnt_d = '0;
    else if (frame_inc && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);

    err_cnt_d = err_cnt_q;
    if (clr_cnt_i)                   err_cnt_d = '0;
    else if (err && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/xgmii32_to_xgmii64_packer.sv
// Packs checked 32-bit XGMII words into 64-bit words, no realignment.
//   clk, rst  : clock (clk_tx domain), async active-high reset
//   rx        : 32-bit XGMII input from the retransmit FIFO
//   tx        : 64-bit XGMII output, ena pulses once per two consumed words
//   clr_cnt   : synchronous clear of both counters
//   frame_cnt : frames started, err_cnt : words replaced by error codes
module xgmii32_to_xgmii64_packer
  import xgmii32_to_xgmii64_packer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  xgmii32_t         rx,
  output xgmii64_t         tx,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic        half_q, half_d;
  logic [31:0] low_data_q, low_data_d;
  logic [3:0]  low_ctrl_q, low_ctrl_d;
  xgmii64_t    tx_q, tx_d;
  logic [31:0] chk_data;
  logic [3:0]  chk_ctrl;

  xgmii32_frame_check #(
    .CNT_W(CNT_W)
  ) u_check (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .clr_cnt_i  (clr_cnt),
    .chk_data_o (chk_data),
    .chk_ctrl_o (chk_ctrl),
    .frame_cnt_o(frame_cnt),
    .err_cnt_o  (err_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q     <= 1'b0;
      low_data_q <= '0;
      low_ctrl_q <= '0;
      tx_q       <= '{data: {8{XGMII_IDLE}}, ctrl: '1, ena: 1'b0};
    end else begin
      half_q     <= half_d;
      low_data_q <= low_data_d;
      low_ctrl_q <= low_ctrl_d;
      tx_q       <= tx_d;
    end
  end

  // tx data/ctrl hold between pulses; only ena drops back to 0.
  always_comb begin
    half_d     = half_q;
    low_data_d = low_data_q;
    low_ctrl_d = low_ctrl_q;
    tx_d       = tx_q;
    tx_d.ena   = 1'b0;
    if (rx.ena) begin
      if (!half_q) begin
        low_data_d = chk_data;
        low_ctrl_d = chk_ctrl;
        half_d     = 1'b1;
      end else begin
        tx_d.data = {chk_data, low_data_q};
        tx_d.ctrl = {chk_ctrl, low_ctrl_q};
        tx_d.ena  = 1'b1;
        half_d    = 1'b0;
      end
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_xgmii32_to_xgmii64_packer.sv
module tb_xgmii32_to_xgmii64_packer;
  import xgmii32_to_xgmii64_packer_pkg::*;

  localparam int unsigned CW = 5;
  localparam longint CMAX = (64'd1 << CW) - 1;

  localparam logic [31:0] WI  = 32'h07070707;
  localparam logic [31:0] WS  = 32'h555555FB;
  localparam logic [31:0] WD1 = 32'h11223344;
  localparam logic [31:0] WD2 = 32'h55667788;
  localparam logic [31:0] WD3 = 32'h99AABBCC;
  localparam logic [31:0] WT  = 32'h0707FDFD; // ctrl 1110: FD in byte1, byte0 also FD (data)
  localparam logic [31:0] WE  = 32'hFEFEFEFE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_cnt = 1'b0;
  xgmii32_t      rx = '0;
  xgmii64_t      tx;
  logic [CW-1:0] frame_cnt, err_cnt;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  xgmii32_to_xgmii64_packer #(
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .tx       (tx),
    .clr_cnt  (clr_cnt),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c, input logic e, input logic clr);
    @(negedge clk);
    rx.data = d; rx.ctrl = c; rx.ena = e; clr_cnt = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx = '0; clr_cnt = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic        e;
    logic        exp_e;
    logic [63:0] exp_d;
    logic [7:0]  exp_c;
    int          frm;
    int          err;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [31:0] d, input logic [3:0] c, input logic e,
                              input logic exp_e, input logic [63:0] exp_d, input logic [7:0] exp_c,
                              input int frm, input int err);
    vec_t v;
    v.d = d; v.c = c; v.e = e; v.exp_e = exp_e; v.exp_d = exp_d; v.exp_c = exp_c;
    v.frm = frm; v.err = err;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  typedef enum int { K_START, K_DATA, K_TERM, K_IDLE, K_OTHER } kind_e;

  bit          m_in_frame;
  logic [35:0] m_q[$];
  logic [63:0] m_data;
  logic [7:0]  m_ctrl;
  logic        m_ena;
  longint      m_frm, m_err;

  function automatic kind_e kind_of(input logic [31:0] d, input logic [3:0] c);
    logic [7:0] b0, b1, b2, b3;
    bit ok;
    b0 = d[7:0]; b1 = d[15:8]; b2 = d[23:16]; b3 = d[31:24];
    if (c == 4'b0001 && b0 == 8'hFB) return K_START;
    if (c == 4'b0000) return K_DATA;
    if (c == 4'b1111 && d == 32'h07070707) return K_IDLE;
    case (c)
      4'b1111: ok = (b0 == 8'hFD) && (b1 == 8'h07) && (b2 == 8'h07) && (b3 == 8'h07);
      4'b1110: ok = (b1 == 8'hFD) && (b2 == 8'h07) && (b3 == 8'h07);
      4'b1100: ok = (b2 == 8'hFD) && (b3 == 8'h07);
      4'b1000: ok = (b3 == 8'hFD);
      default: ok = 1'b0;
    endcase
    return ok ? K_TERM : K_OTHER;
  endfunction

  function automatic void model_reset();
    m_in_frame = 1'b0;
    m_q.delete();
    m_data = 64'h0707070707070707; m_ctrl = 8'hFF; m_ena = 1'b0;
    m_frm = 0; m_err = 0;
  endfunction

  function automatic void model_step(input logic [31:0] d, input logic [3:0] c, input logic e,
                                     input logic clr);
    kind_e k;
    bit bad, fr;
    logic [35:0] lo, hi;
    m_ena = 1'b0; bad = 1'b0; fr = 1'b0;
    if (e) begin
      k = kind_of(d, c);
      if (!m_in_frame) begin
        if (k == K_START) begin m_in_frame = 1'b1; fr = 1'b1; end
        else if (k != K_IDLE) bad = 1'b1;
      end else begin
        if (k == K_TERM) m_in_frame = 1'b0;
        else if (k == K_START) begin bad = 1'b1; fr = 1'b1; end
        else if (k != K_DATA) begin bad = 1'b1; m_in_frame = 1'b0; end
      end
      m_q.push_back(bad ? {4'hF, 32'hFEFEFEFE} : {c, d});
      if (m_q.size() == 2) begin
        lo = m_q.pop_front();
        hi = m_q.pop_front();
        m_data = {hi[31:0], lo[31:0]};
        m_ctrl = {hi[35:32], lo[35:32]};
        m_ena  = 1'b1;
      end
    end
    if (clr) begin
      m_frm = 0; m_err = 0;
    end else begin
      if (fr  && m_frm < CMAX) m_frm++;
      if (bad && m_err < CMAX) m_err++;
    end
  endfunction

  function automatic void rand_word(output logic [31:0] d, output logic [3:0] c);
    int unsigned l;
    d = $urandom; c = 4'(($urandom));
    case ($urandom_range(0, 9))
      0, 1: begin d = WI; c = 4'hF; end
      2:    begin d[7:0] = 8'hFB; c = 4'b0001; end
      3, 4, 5: c = 4'b0000;
      6: begin
        l = $urandom_range(0, 3);
        c = 4'hF << l;
        d[8*l +: 8] = 8'hFD;
        for (int unsigned b = l + 1; b < 4; b++) d[8*b +: 8] = 8'h07;
      end
      7: begin d = WE; c = 4'hF; end
      default: ;
    endcase
  endfunction

  initial begin
    logic [31:0] w_d[64];
    logic [3:0]  w_c[64];
    logic [31:0] rd;
    logic [3:0]  rc;
    logic        re, rclr;
    int unsigned k, ntx;

    // -------- reset values --------
    @(posedge clk); #1;
    chk("reset.tx_data", tx.data, 64'h0707070707070707);
    chk("reset.tx_ctrl", {56'd0, tx.ctrl}, 64'hFF);
    chk("reset.tx_ena", {63'd0, tx.ena}, 64'd0);
    chk("reset.frame_cnt", 64'(frame_cnt), 64'd0);
    chk("reset.err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk); rst = 1'b0;

    // -------- table --------
    for (int i = 0; i < 8; i++)
      add(WI, 4'hF, 1, i[0], 64'h0707070707070707, 8'hFF, 0, 0);
    // frame with Start in lane 0
    add(WS, 4'h1, 1, 0, 64'h0, 8'h0, 1, 0);
    add(32'hDEADBEEF, 4'h5, 0, 0, 64'h0, 8'h0, 1, 0);
    add(WD1, 4'h0, 1, 1, {WD1, WS}, 8'h01, 1, 0);
    add(WD2, 4'h0, 1, 0, 64'h0, 8'h0, 1, 0);
    add(WD3, 4'h0, 1, 1, {WD3, WD2}, 8'h00, 1, 0);
    add(WT, 4'hE, 1, 0, 64'h0, 8'h0, 1, 0);
    add(WI, 4'hF, 1, 1, {WI, WT}, 8'hFE, 1, 0);
    // frame with Start in lane 4
    add(WI, 4'hF, 1, 0, 64'h0, 8'h0, 1, 0);
    add(WS, 4'h1, 1, 1, {WS, WI}, 8'h1F, 2, 0);
    add(WD1, 4'h0, 1, 0, 64'h0, 8'h0, 2, 0);
    add(WD2, 4'h0, 1, 1, {WD2, WD1}, 8'h00, 2, 0);
    add(WD3, 4'h0, 1, 0, 64'h0, 8'h0, 2, 0);
    add(WT, 4'hE, 1, 1, {WT, WD3}, 8'hE0, 2, 0);
    // Data in IDLE, Idle in FRAME, then a clean Start proves IDLE
    add(WD1, 4'h0, 1, 0, 64'h0, 8'h0, 2, 1);
    add(WS, 4'h1, 1, 1, {WS, WE}, 8'h1F, 3, 1);
    add(WI, 4'hF, 1, 0, 64'h0, 8'h0, 3, 2);
    add(32'h0, 4'h0, 0, 0, 64'h0, 8'h0, 3, 2);
    add(WI, 4'hF, 1, 1, {WI, WE}, 8'hFF, 3, 2);
    add(WS, 4'h1, 1, 0, 64'h0, 8'h0, 4, 2);
    add(WD1, 4'h0, 1, 1, {WD1, WS}, 8'h01, 4, 2);

    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].c, vecs[i].e, 1'b0);
      chk($sformatf("vec%0d.ena", i), {63'd0, tx.ena}, {63'd0, vecs[i].exp_e});
      if (vecs[i].exp_e) begin
        chk($sformatf("vec%0d.data", i), tx.data, vecs[i].exp_d);
        chk($sformatf("vec%0d.ctrl", i), {56'd0, tx.ctrl}, {56'd0, vecs[i].exp_c});
      end
      chk($sformatf("vec%0d.frame_cnt", i), 64'(frame_cnt), 64'(vecs[i].frm));
      chk($sformatf("vec%0d.err_cnt", i), 64'(err_cnt), 64'(vecs[i].err));
    end

    // -------- FIFO-style ena gaps over 66 cycles --------
    do_reset();
    for (int i = 0; i < 64; i++) begin
      w_d[i] = {16'hA5C3, 16'(i)}; w_c[i] = 4'h0;
    end
    w_d[0] = WS; w_c[0] = 4'h1;
    w_d[63] = WT; w_c[63] = 4'hE;
    k = 0; ntx = 0;
    for (int cyc = 0; cyc < 66; cyc++) begin
      if (cyc == 16 || cyc == 49) begin
        drive(32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        chk("gap.ena", {63'd0, tx.ena}, 64'd0);
      end else begin
        drive(w_d[k], w_c[k], 1'b1, 1'b0);
        if (k[0]) begin
          chk($sformatf("gap.w%0d.data", k), tx.data, {w_d[k], w_d[k-1]});
          chk($sformatf("gap.w%0d.ctrl", k), {56'd0, tx.ctrl}, {56'd0, w_c[k], w_c[k-1]});
        end
        k++;
      end
      if (tx.ena) ntx++;
    end
    chk("gap.tx_words", 64'(ntx), 64'd32);
    chk("gap.frame_cnt", 64'(frame_cnt), 64'd1);
    chk("gap.err_cnt", 64'(err_cnt), 64'd0);

    // -------- saturation and clear --------
    do_reset();
    for (int i = 0; i < int'(CMAX) - 1; i++) drive(WD1, 4'h0, 1'b1, 1'b0);
    chk("sat.preload", 64'(err_cnt), 64'(CMAX - 1));
    for (int i = 0; i < 3; i++) begin
      drive(WD1, 4'h0, 1'b1, 1'b0);
      chk($sformatf("sat.err%0d", i), 64'(err_cnt), 64'(CMAX));
    end
    drive(WD1, 4'h0, 1'b1, 1'b1);
    chk("sat.clr_with_err", 64'(err_cnt), 64'd0);
    drive(WS, 4'h1, 1'b1, 1'b1);
    chk("sat.clr_with_start", 64'(frame_cnt), 64'd0);

    // -------- reset with a pending low half --------
    do_reset();
    drive(WD1, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; rx.ena = 1'b0;
    @(posedge clk); #1;
    chk("midrst.ena", {63'd0, tx.ena}, 64'd0);
    @(negedge clk); rst = 1'b0;
    drive(WI, 4'hF, 1'b1, 1'b0);
    chk("midrst.first_ena", {63'd0, tx.ena}, 64'd0);
    drive(WS, 4'h1, 1'b1, 1'b0);
    chk("midrst.ena2", {63'd0, tx.ena}, 64'd1);
    chk("midrst.low_lane", {32'd0, tx.data[31:0]}, {32'd0, WI});
    chk("midrst.high_lane", {32'd0, tx.data[63:32]}, {32'd0, WS});

    // -------- randomized against the model --------
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_word(rd, rc);
      re   = ($urandom_range(0, 9) < 8);
      rclr = ($urandom_range(0, 99) < 2);
      model_step(rd, rc, re, rclr);
      drive(rd, rc, re, rclr);
      chk($sformatf("rnd%0d.ena", i), {63'd0, tx.ena}, {63'd0, m_ena});
      chk($sformatf("rnd%0d.data", i), tx.data, m_data);
      chk($sformatf("rnd%0d.ctrl", i), {56'd0, tx.ctrl}, {56'd0, m_ctrl});
      chk($sformatf("rnd%0d.frame_cnt", i), 64'(frame_cnt), 64'(m_frm));
      chk($sformatf("rnd%0d.err_cnt", i), 64'(err_cnt), 64'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
